// File: rtl/vga_pkg.sv
// Shared types and default 640x480@25MHz timing for the VGA test-pattern sequencer.
package vga_pkg;

  typedef enum logic [2:0] {
    PAT_OFF,
    PAT_RED,
    PAT_GRN,
    PAT_BLU,
    PAT_CHECKER,
    PAT_BARS,
    PAT_BORDER
  } pattern_t;

  typedef enum logic {
    IDLE,
    PENDING
  } seq_state_t;

  localparam int DEF_TOTAL_COLS    = 800;
  localparam int DEF_TOTAL_ROWS    = 525;
  localparam int DEF_ACTIVE_COLS   = 640;
  localparam int DEF_ACTIVE_ROWS   = 480;
  localparam int DEF_H_FRONT_PORCH = 16;
  localparam int DEF_H_SYNC_WIDTH  = 96;
  localparam int DEF_V_FRONT_PORCH = 10;
  localparam int DEF_V_SYNC_WIDTH  = 2;
  localparam int DEF_DWELL_FRAMES  = 60;

  // Index 7 has no pattern behind it, so it selects the blank output.
  function automatic pattern_t sanitize(input logic [2:0] idx);
    return (idx > 3'd6) ? PAT_OFF : pattern_t'(idx);
  endfunction

  // Auto-cycle order skips PAT_OFF: 0->1 ... 5->6, 6->1.
  function automatic pattern_t next_auto(input pattern_t p);
    return (p == PAT_BORDER) ? PAT_RED : pattern_t'(p + 3'd1);
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Raster col/row counters with registered sync/active decode aligned to the presented position.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int TOTAL_COLS    = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS    = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS   = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS   = DEF_ACTIVE_ROWS,
  parameter int H_FRONT_PORCH = DEF_H_FRONT_PORCH,
  parameter int H_SYNC_WIDTH  = DEF_H_SYNC_WIDTH,
  parameter int V_FRONT_PORCH = DEF_V_FRONT_PORCH,
  parameter int V_SYNC_WIDTH  = DEF_V_SYNC_WIDTH
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       wrap
);

  localparam logic [9:0] LAST_COL = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] LAST_ROW = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] ACT_COLS = 10'(ACTIVE_COLS);
  localparam logic [9:0] ACT_ROWS = 10'(ACTIVE_ROWS);
  localparam logic [9:0] HS_FIRST = 10'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [9:0] HS_LAST  = 10'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
  localparam logic [9:0] VS_FIRST = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [9:0] VS_LAST  = 10'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);

  logic [9:0] col_nxt;
  logic [9:0] row_nxt;

  assign wrap = (col == LAST_COL) && (row == LAST_ROW);

  always_comb begin
    col_nxt = col + 10'd1;
    row_nxt = row;
    if (col == LAST_COL) begin
      col_nxt = '0;
      row_nxt = (row == LAST_ROW) ? 10'd0 : row + 10'd1;
    end
  end

  // Decode from the next position so flags land in the same cycle as the col/row they describe.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      col         <= '0;
      row         <= '0;
      active      <= 1'b1;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      col         <= col_nxt;
      row         <= row_nxt;
      active      <= (col_nxt < ACT_COLS) && (row_nxt < ACT_ROWS);
      hsync       <= !((col_nxt >= HS_FIRST) && (col_nxt <= HS_LAST));
      vsync       <= !((row_nxt >= VS_FIRST) && (row_nxt <= VS_LAST));
      frame_start <= wrap;
    end
  end

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Pattern scheduler: applies requested patterns only on frame wrap so no frame is torn.
// Optional dwell-based auto-cycling is enabled by defining PATTERN_AUTO_CYCLE_EN.
//
// state   | meaning
// IDLE    | ready for a pattern request
// PENDING | request latched, waiting for the frame wrap to apply it
module vga_pattern_sequencer
  import vga_pkg::*;
#(
  parameter int TOTAL_COLS    = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS    = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS   = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS   = DEF_ACTIVE_ROWS,
  parameter int H_FRONT_PORCH = DEF_H_FRONT_PORCH,
  parameter int H_SYNC_WIDTH  = DEF_H_SYNC_WIDTH,
  parameter int V_FRONT_PORCH = DEF_V_FRONT_PORCH,
  parameter int V_SYNC_WIDTH  = DEF_V_SYNC_WIDTH
`ifdef PATTERN_AUTO_CYCLE_EN
  , parameter int DWELL_FRAMES = DEF_DWELL_FRAMES
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sel_valid,
  input  logic [2:0] sel_pattern,
  output logic       sel_ready,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic [2:0] pattern
);

  seq_state_t state, state_nxt;
  pattern_t   pattern_q, pattern_nxt;
  pattern_t   pend_q, pend_nxt;
  logic       wrap;

  vga_timing_counter #(
    .TOTAL_COLS   (TOTAL_COLS),
    .TOTAL_ROWS   (TOTAL_ROWS),
    .ACTIVE_COLS  (ACTIVE_COLS),
    .ACTIVE_ROWS  (ACTIVE_ROWS),
    .H_FRONT_PORCH(H_FRONT_PORCH),
    .H_SYNC_WIDTH (H_SYNC_WIDTH),
    .V_FRONT_PORCH(V_FRONT_PORCH),
    .V_SYNC_WIDTH (V_SYNC_WIDTH)
  ) u_timing (
    .clock      (clock),
    .reset_n    (reset_n),
    .col        (col),
    .row        (row),
    .active     (active),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_start(frame_start),
    .wrap       (wrap)
  );

  assign sel_ready = (state == IDLE);
  assign pattern   = pattern_q;

`ifdef PATTERN_AUTO_CYCLE_EN
  logic [9:0]  frame_cnt, frame_cnt_nxt;
  logic [10:0] frame_cnt_inc;

  assign frame_cnt_inc = {1'b0, frame_cnt} + 11'd1;

  always_ff @(posedge clock) begin
    if (!reset_n) frame_cnt <= '0;
    else          frame_cnt <= frame_cnt_nxt;
  end
`endif

  always_comb begin
    state_nxt   = state;
    pattern_nxt = pattern_q;
    pend_nxt    = pend_q;
`ifdef PATTERN_AUTO_CYCLE_EN
    frame_cnt_nxt = frame_cnt;
`endif
    case (state)
      IDLE: begin
        if (sel_valid) begin
          pend_nxt  = sanitize(sel_pattern);
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (wrap) begin
          pattern_nxt = pend_q;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef PATTERN_AUTO_CYCLE_EN
    // A pending manual request owns the wrap and restarts the dwell.
    if (wrap) begin
      if (state == PENDING) begin
        frame_cnt_nxt = '0;
      end else if (frame_cnt_inc >= 11'(DWELL_FRAMES)) begin
        pattern_nxt   = next_auto(pattern_q);
        frame_cnt_nxt = '0;
      end else begin
        frame_cnt_nxt = frame_cnt_inc[9:0];
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      pattern_q <= PAT_OFF;
      pend_q    <= PAT_OFF;
    end else begin
      state     <= state_nxt;
      pattern_q <= pattern_nxt;
      pend_q    <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Randomized and directed bench for vga_pattern_sequencer on a reduced raster, with a position/request reference model.
module tb_vga_pattern_sequencer;

  localparam int TC    = 80;
  localparam int TR    = 30;
  localparam int AC    = 56;
  localparam int AR    = 22;
  localparam int HFP   = 4;
  localparam int HSW   = 8;
  localparam int VFP   = 2;
  localparam int VSW   = 2;
  localparam int DWELL = 2;
  localparam int FRAME = TC * TR;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       sel_valid = 1'b0;
  logic [2:0] sel_pattern = 3'd0;
  logic       sel_ready;
  logic [9:0] col, row;
  logic       active, hsync, vsync, frame_start;
  logic [2:0] pattern;

  vga_pattern_sequencer #(
    .TOTAL_COLS   (TC),
    .TOTAL_ROWS   (TR),
    .ACTIVE_COLS  (AC),
    .ACTIVE_ROWS  (AR),
    .H_FRONT_PORCH(HFP),
    .H_SYNC_WIDTH (HSW),
    .V_FRONT_PORCH(VFP),
    .V_SYNC_WIDTH (VSW)
`ifdef PATTERN_AUTO_CYCLE_EN
    , .DWELL_FRAMES(DWELL)
`endif
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .sel_valid  (sel_valid),
    .sel_pattern(sel_pattern),
    .sel_ready  (sel_ready),
    .col        (col),
    .row        (row),
    .active     (active),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_start(frame_start),
    .pattern    (pattern)
  );

  always #20 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: raster position as a linear index into the frame, plus request bookkeeping.
  int t = 0;
  int m_pat = 0;
  bit m_pend = 0;
  int m_pv = 0;
  int m_cnt = 0;
  bit m_fs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expected_bundle();
    int c, r;
    bit a, hs, vs;
    c  = t % TC;
    r  = t / TC;
    a  = (c < AC) && (r < AR);
    hs = !((c >= AC + HFP) && (c < AC + HFP + HSW));
    vs = !((r >= AR + VFP) && (r < AR + VFP + VSW));
    return {4'd0, !m_pend, c[9:0], r[9:0], a, hs, vs, m_fs, m_pat[2:0]};
  endfunction

  function automatic logic [31:0] observed_bundle();
    return {4'd0, sel_ready, col, row, active, hsync, vsync, frame_start, pattern};
  endfunction

  task automatic tick();
    bit wrap, accept;
    @(posedge clock);
    if (!reset_n) begin
      t = 0; m_pat = 0; m_pend = 0; m_cnt = 0; m_fs = 0;
    end else begin
      wrap   = (t == FRAME - 1);
      accept = sel_valid && !m_pend;
      if (wrap) begin
        if (m_pend) begin
          m_pat = m_pv; m_pend = 0; m_cnt = 0;
        end
`ifdef PATTERN_AUTO_CYCLE_EN
        else begin
          m_cnt++;
          if (m_cnt >= DWELL) begin
            m_pat = (m_pat == 6) ? 1 : m_pat + 1;
            m_cnt = 0;
          end
        end
`endif
      end
      if (accept) begin
        m_pend = 1;
        m_pv   = (sel_pattern > 3'd6) ? 0 : int'(sel_pattern);
      end
      t    = (t + 1) % FRAME;
      m_fs = wrap;
    end
    #1;
    chk("cycle", observed_bundle(), expected_bundle());
  endtask

  task automatic run_to(input int pos);
    for (int n = 0; n < FRAME + 1 && t != pos; n++) tick();
  endtask

  task automatic wait_fs(input string tag);
    for (int n = 0; n < FRAME + 2; n++) begin
      tick();
      if (frame_start) break;
    end
    chk(tag, frame_start, 1);
  endtask

  // Hold a request until a handshake completes (sel_ready seen before the edge).
  task automatic send(input logic [2:0] p);
    bit rdy, done;
    done = 0;
    sel_valid = 1'b1;
    sel_pattern = p;
    for (int n = 0; n < 2 * FRAME + 4 && !done; n++) begin
      rdy = sel_ready;
      tick();
      done = rdy;
    end
    sel_valid = 1'b0;
    chk("send_accept", done, 1);
  endtask

  initial begin
    int period, act_cnt, hs_low, hs_first, vs_min, vs_max, vs_cnt;
    bit rdy, rst_now;

    reset_n = 1'b0;
    tick();
    tick();
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    chk("rst_active", active, 1);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_fs", frame_start, 0);
    chk("rst_pattern", pattern, 0);
    chk("rst_ready", sel_ready, 1);
    reset_n = 1'b1;

`ifndef PATTERN_AUTO_CYCLE_EN
    // Free-run frame statistics between two frame_start pulses.
    wait_fs("fs_first");
    period = 0; act_cnt = 0; hs_low = 0; hs_first = -1; vs_min = 1023; vs_max = -1; vs_cnt = 0;
    for (int n = 0; n < FRAME + 2; n++) begin
      if (active) act_cnt++;
      if (row == 0 && !hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(col);
      end
      if (!vsync) begin
        vs_cnt++;
        if (int'(row) < vs_min) vs_min = int'(row);
        if (int'(row) > vs_max) vs_max = int'(row);
      end
      tick();
      period++;
      if (frame_start) break;
    end
    chk("frame_period", period, FRAME);
    chk("active_count", act_cnt, AC * AR);
    chk("hsync_low_len", hs_low, HSW);
    chk("hsync_first_col", hs_first, AC + HFP);
    chk("vsync_first_row", vs_min, AR + VFP);
    chk("vsync_last_row", vs_max, AR + VFP + VSW - 1);
    chk("vsync_low_cycles", vs_cnt, VSW * TC);

    // Mid-frame request applies exactly on the wrap.
    run_to(10 * TC);
    sel_valid = 1'b1; sel_pattern = 3'd4;
    tick();
    sel_valid = 1'b0;
    chk("req4_ready_low", sel_ready, 0);
    chk("req4_pattern_hold", pattern, 0);
    wait_fs("req4_fs");
    chk("req4_applied", pattern, 4);
    tick();
    chk("req4_ready_back", sel_ready, 1);

    // Out-of-range index blanks; a request held through PENDING lands one frame later.
    send(3'd7);
    send(3'd2);
    chk("req7_applied", pattern, 0);
    wait_fs("req2_fs");
    chk("req2_applied", pattern, 2);

    // Request accepted on the wrap cycle waits a full frame.
    run_to(FRAME - 1);
    sel_valid = 1'b1; sel_pattern = 3'd5;
    tick();
    sel_valid = 1'b0;
    chk("wrapreq_fs", frame_start, 1);
    chk("wrapreq_unchanged", pattern, 2);
    chk("wrapreq_ready_low", sel_ready, 0);
    wait_fs("wrapreq_fs2");
    chk("wrapreq_applied", pattern, 5);

    // Reset while PENDING discards the pending pattern.
    run_to(15 * TC);
    send(3'd6);
    run_to(20 * TC + 30);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midrst_col", col, 0);
    chk("midrst_row", row, 0);
    chk("midrst_pattern", pattern, 0);
    chk("midrst_ready", sel_ready, 1);
    chk("midrst_fs", frame_start, 0);
    chk("midrst_syncs", {active, hsync, vsync}, 3'b111);
    wait_fs("midrst_fs2");
    chk("midrst_dropped", pattern, 0);
`else
    // Dwell auto-cycle: advance every DWELL frames, 6 wraps back to 1.
    begin
      int seq [7] = '{1, 2, 3, 4, 5, 6, 1};
      for (int k = 1; k <= 14; k++) begin
        wait_fs("auto_fs");
        if (k % 2 == 0) chk("auto_seq", pattern, seq[k / 2 - 1]);
      end
    end
    run_to(5 * TC);
    send(3'd3);
    wait_fs("auto_manual_fs");
    chk("auto_manual_wins", pattern, 3);
    wait_fs("auto_restart_fs1");
    chk("auto_restart_hold", pattern, 3);
    wait_fs("auto_restart_fs2");
    chk("auto_restart_adv", pattern, 4);
`endif

    // Random requests and occasional resets, all checked by the model every cycle.
    for (int i = 0; i < 8000; i++) begin
      if (!sel_valid && $urandom_range(0, 299) == 0) begin
        sel_valid = 1'b1;
        sel_pattern = 3'($urandom_range(0, 7));
      end
      rst_now = ($urandom_range(0, 3999) == 0);
      if (rst_now) reset_n = 1'b0;
      rdy = sel_ready;
      tick();
      reset_n = 1'b1;
      if (sel_valid && rdy && !rst_now) sel_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
